// File: rtl/machine_ctrl.sv
// Instruction sequencer for the 8-bit accumulator CPU: an 8-phase cycle per
// instruction with control strobes decoded from phase, opcode and the halt/skip flags.
module machine_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       inc_pc,
   output logic       load_pc,
   output logic       load_acc,
   output logic       load_ir,
   output logic       rd,
   output logic       wr,
   output logic       datactl_ena,
   output logic       halt,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      P_FETCH_HI = 3'd0,
      P_FETCH_LO = 3'd1,
      P_DECODE   = 3'd2,
      P_CHECK    = 3'd3,
      P_OPER     = 3'd4,
      P_EXEC     = 3'd5,
      P_POST     = 3'd6,
      P_END      = 3'd7
   } phase_t;

   typedef enum logic [2:0] {
      OP_HLT  = 3'b000,
      OP_SKZ  = 3'b001,
      OP_ADD  = 3'b010,
      OP_ANDD = 3'b011,
      OP_XORR = 3'b100,
      OP_LDA  = 3'b101,
      OP_STO  = 3'b110,
      OP_JMP  = 3'b111
   } op_t;

   phase_t state;
   logic   halted;
   logic   skip;
   op_t    op;
   logic   alu_class;
   logic   hlt_now;

   assign op        = op_t'(opcode);
   assign alu_class = (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
   // HLT in CHECK wins over a simultaneous ena drop.
   assign hlt_now   = !halted && (state == P_CHECK) && (op == OP_HLT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= P_FETCH_HI;
         halted <= 1'b0;
         skip   <= 1'b0;
      end else if (halted) begin
         state  <= state;
      end else if (hlt_now) begin
         halted <= 1'b1;
      end else if (!ena) begin
         state  <= P_FETCH_HI;
         skip   <= 1'b0;
      end else begin
         state <= phase_t'(3'(state + 3'd1));
         if (state == P_EXEC && op == OP_SKZ)
            skip <= zero;
         else if (state == P_END)
            skip <= 1'b0;
      end
   end

   always_comb begin
      inc_pc      = 1'b0;
      load_pc     = 1'b0;
      load_acc    = 1'b0;
      load_ir     = 1'b0;
      rd          = 1'b0;
      wr          = 1'b0;
      datactl_ena = 1'b0;
      halt        = 1'b0;
      phase       = rst_n ? state : 3'd0;
      if (!rst_n) begin
         halt = 1'b0;
      end else if (halted || hlt_now) begin
         halt = 1'b1;
      end else if (ena) begin
         case (state)
            P_FETCH_HI, P_FETCH_LO: begin
               rd      = 1'b1;
               load_ir = 1'b1;
               inc_pc  = 1'b1;
            end
            P_OPER: begin
               rd          = alu_class;
               load_pc     = (op == OP_JMP);
               datactl_ena = (op == OP_STO);
            end
            P_EXEC: begin
               rd          = alu_class;
               load_acc    = alu_class;
               load_pc     = (op == OP_JMP);
               wr          = (op == OP_STO);
               datactl_ena = (op == OP_STO);
               inc_pc      = (op == OP_SKZ) && zero;
            end
            P_POST: begin
               datactl_ena = (op == OP_STO);
               inc_pc      = (op == OP_SKZ) && skip;
            end
            default: begin
               inc_pc = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_machine_ctrl.sv
// Bench for machine_ctrl: vector table of per-cycle inputs and expected strobes,
// plus a hand-driven halted sequence with randomised ena/opcode.
module tb_machine_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic [2:0] opcode = 3'd0;
   logic       zero = 1'b0;
   logic       inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt;
   logic [2:0] phase;

   int checks = 0;
   int errors = 0;

   localparam logic [7:0] S_INC = 8'h80, S_LP = 8'h40, S_LA = 8'h20, S_IR = 8'h10;
   localparam logic [7:0] S_RD  = 8'h08, S_WR = 8'h04, S_DE = 8'h02, S_H  = 8'h01;
   localparam logic [7:0] S_FETCH = S_INC | S_IR | S_RD;

   typedef struct {
      logic        rst_n;
      logic        ena;
      logic [2:0]  opcode;
      logic        zero;
      logic [10:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];
   logic [10:0] exp_q[$];

   machine_ctrl dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
      .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc), .load_ir(load_ir),
      .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .halt(halt), .phase(phase)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic e, input logic [2:0] op, input logic z,
                      input logic [7:0] s, input logic [2:0] ph, input string nm);
      vec_t v;
      v.rst_n = r; v.ena = e; v.opcode = op; v.zero = z;
      v.exp = {s, ph}; v.name = nm;
      vecs.push_back(v);
   endtask

   // One full instruction with ena=1; zero is z5 in P5 and z_rest elsewhere.
   task automatic add_instr(input logic [2:0] op, input logic z5, input logic z_rest,
                            input logic [7:0] s4, input logic [7:0] s5,
                            input logic [7:0] s6, input string nm);
      add(1, 1, op, z_rest, S_FETCH, 3'd0, {nm, "_p0"});
      add(1, 1, op, z_rest, S_FETCH, 3'd1, {nm, "_p1"});
      add(1, 1, op, z_rest, 8'h00,   3'd2, {nm, "_p2"});
      add(1, 1, op, z_rest, 8'h00,   3'd3, {nm, "_p3"});
      add(1, 1, op, z_rest, s4,      3'd4, {nm, "_p4"});
      add(1, 1, op, z5,     s5,      3'd5, {nm, "_p5"});
      add(1, 1, op, z_rest, s6,      3'd6, {nm, "_p6"});
      add(1, 1, op, z_rest, 8'h00,   3'd7, {nm, "_p7"});
   endtask

   // Drive at the falling edge, queue the expectation, sample before the next rise.
   task automatic run_vec(input vec_t v);
      logic [10:0] got, want;
      @(negedge clk);
      rst_n = v.rst_n; ena = v.ena; opcode = v.opcode; zero = v.zero;
      exp_q.push_back(v.exp);
      #2;
      got  = {inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt, phase};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got strobes=%b phase=%0d, expected strobes=%b phase=%0d",
                  v.name, got[10:3], got[2:0], want[10:3], want[2:0]);
      end
   endtask

   initial begin
      vec_t v;
      // Reset held with ena=1 and JMP on the opcode bus.
      for (int i = 0; i < 3; i++) add(0, 1, 3'b111, 0, 8'h00, 3'd0, "reset_hold");
      add_instr(3'b010, 0, 0, S_RD, S_RD | S_LA, 8'h00, "add");
      add_instr(3'b001, 1, 1, 8'h00, S_INC, S_INC, "skz_z1");
      add_instr(3'b001, 1, 0, 8'h00, S_INC, S_INC, "skz_z1_then0");
      add_instr(3'b001, 0, 1, 8'h00, 8'h00, 8'h00, "skz_z0_then1");
      add_instr(3'b110, 0, 0, S_DE, S_WR | S_DE, S_DE, "sto");
      add_instr(3'b111, 0, 0, S_LP, S_LP, 8'h00, "jmp");
      add_instr(3'b011, 1, 1, S_RD, S_RD | S_LA, 8'h00, "andd");
      add_instr(3'b100, 0, 0, S_RD, S_RD | S_LA, 8'h00, "xorr");
      // Abort an LDA in P4, hold ena low, then a clean LDA.
      add(1, 1, 3'b101, 0, S_FETCH, 3'd0, "abort_p0");
      add(1, 1, 3'b101, 0, S_FETCH, 3'd1, "abort_p1");
      add(1, 1, 3'b101, 0, 8'h00, 3'd2, "abort_p2");
      add(1, 1, 3'b101, 0, 8'h00, 3'd3, "abort_p3");
      add(1, 0, 3'b101, 0, 8'h00, 3'd4, "abort_drop");
      for (int i = 0; i < 3; i++) add(1, 0, 3'b101, 0, 8'h00, 3'd0, "abort_idle");
      add_instr(3'b101, 0, 0, S_RD, S_RD | S_LA, 8'h00, "lda_after_abort");
      // Reset mid-instruction, combined with ena=0.
      add(1, 1, 3'b110, 0, S_FETCH, 3'd0, "rstmid_p0");
      add(1, 1, 3'b110, 0, S_FETCH, 3'd1, "rstmid_p1");
      add(1, 1, 3'b110, 0, 8'h00, 3'd2, "rstmid_p2");
      add(1, 1, 3'b110, 0, 8'h00, 3'd3, "rstmid_p3");
      add(1, 1, 3'b110, 0, S_DE, 3'd4, "rstmid_p4");
      add(0, 0, 3'b110, 0, 8'h00, 3'd0, "rstmid_assert");
      add(1, 1, 3'b110, 0, S_FETCH, 3'd0, "rstmid_restart");
      add(1, 1, 3'b110, 0, S_FETCH, 3'd1, "rstmid_restart_p1");
      // HLT reached in P3 while ena drops: halt still wins.
      add(1, 1, 3'b000, 0, 8'h00, 3'd2, "hlt_ena0_p2");
      add(1, 0, 3'b000, 0, S_H, 3'd3, "hlt_ena0_p3");
      add(1, 0, 3'b010, 0, S_H, 3'd3, "hlt_ena0_hold");
      add(0, 1, 3'b000, 0, 8'h00, 3'd0, "hlt_ena0_reset");
      // Normal HLT instruction.
      add(1, 1, 3'b000, 0, S_FETCH, 3'd0, "hlt_p0");
      add(1, 1, 3'b000, 0, S_FETCH, 3'd1, "hlt_p1");
      add(1, 1, 3'b000, 0, 8'h00, 3'd2, "hlt_p2");
      add(1, 1, 3'b000, 0, S_H, 3'd3, "hlt_p3");

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

      // Halted: ena, opcode and zero toggled freely for 20 cycles.
      for (int i = 0; i < 20; i++) begin
         v.rst_n = 1'b1;
         v.ena = 1'($urandom_range(0, 1));
         v.opcode = 3'($urandom_range(0, 7));
         v.zero = 1'($urandom_range(0, 1));
         v.exp = {S_H, 3'd3};
         v.name = "halted_hold";
         run_vec(v);
      end
      v.rst_n = 1'b0; v.ena = 1'b1; v.opcode = 3'b000; v.zero = 1'b0;
      v.exp = {8'h00, 3'd0}; v.name = "halted_reset";
      run_vec(v);
      v.rst_n = 1'b1; v.opcode = 3'b010;
      v.exp = {S_FETCH, 3'd0}; v.name = "halted_release_p0";
      run_vec(v);
      v.exp = {S_FETCH, 3'd1}; v.name = "halted_release_p1";
      run_vec(v);

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete within bound");
      $fatal(1, "timeout");
   end

endmodule
